// File: rtl/vg_mode_ctrl.sv
// Mode-switch sequencer: drains the sync generator to a VS boundary, holds it in reset while loading timing, then restarts it.
// Latency: accept -> HOLD next edge (from IDLE) or after first VS rise (from ACTIVE); HOLD_CYCLES in reset; done one edge after first VS rise.
// Backpressure: req_ready is high only in IDLE/ACTIVE; requests are ignored for the whole sequence.
module vg_mode_ctrl #(
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 12,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 1 << 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_mode,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  input  logic              vs_in,
  output logic              gen_reset_n,
  output logic              mode_valid,
  output logic [1:0]        cur_mode,
  output logic              interlaced,
  output logic [Y_BITS-1:0] v_total_0,
  output logic [Y_BITS-1:0] v_fp_0,
  output logic [Y_BITS-1:0] v_bp_0,
  output logic [Y_BITS-1:0] v_sync_0,
  output logic [Y_BITS-1:0] v_total_1,
  output logic [Y_BITS-1:0] v_fp_1,
  output logic [Y_BITS-1:0] v_bp_1,
  output logic [Y_BITS-1:0] v_sync_1,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] hv_offset_0,
  output logic [X_BITS-1:0] hv_offset_1
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_HOLD, S_START} state_t;

  typedef struct packed {
    logic              il;
    logic [X_BITS-1:0] h_total, h_fp, h_bp, h_sync, hv0, hv1;
    logic [Y_BITS-1:0] vt0, vf0, vb0, vs0, vt1, vf1, vb1, vs1;
  } tmg_t;

  // Fixed mode table; field-1 vertical values equal field 0 except for the interlaced mode.
  function automatic tmg_t mode_tbl(input logic [1:0] m);
    tmg_t t;
    t = '0;
    case (m)
      2'd0: begin
        t.h_total = X_BITS'(1650); t.h_fp = X_BITS'(110); t.h_bp = X_BITS'(220); t.h_sync = X_BITS'(40);
        t.vt0 = Y_BITS'(750); t.vf0 = Y_BITS'(5); t.vb0 = Y_BITS'(20); t.vs0 = Y_BITS'(5);
      end
      2'd1: begin
        t.h_total = X_BITS'(2200); t.h_fp = X_BITS'(88); t.h_bp = X_BITS'(148); t.h_sync = X_BITS'(44);
        t.vt0 = Y_BITS'(1125); t.vf0 = Y_BITS'(4); t.vb0 = Y_BITS'(36); t.vs0 = Y_BITS'(5);
      end
      2'd2: begin
        t.h_total = X_BITS'(2200); t.h_fp = X_BITS'(88); t.h_bp = X_BITS'(148); t.h_sync = X_BITS'(44);
        t.vt0 = Y_BITS'(562); t.vf0 = Y_BITS'(2); t.vb0 = Y_BITS'(15); t.vs0 = Y_BITS'(5);
        t.il  = 1'b1;
        t.hv1 = X_BITS'(1100);
      end
      default: begin
        t.h_total = X_BITS'(858); t.h_fp = X_BITS'(16); t.h_bp = X_BITS'(60); t.h_sync = X_BITS'(62);
        t.vt0 = Y_BITS'(525); t.vf0 = Y_BITS'(9); t.vb0 = Y_BITS'(30); t.vs0 = Y_BITS'(6);
      end
    endcase
    t.vt1 = t.vt0; t.vf1 = t.vf0; t.vb1 = t.vb0; t.vs1 = t.vs0;
    if (m == 2'd2) begin
      t.vt1 = Y_BITS'(563);
      t.vb1 = Y_BITS'(16);
    end
    return t;
  endfunction

  state_t          r_state, w_next;
  logic [1:0]      r_pend_mode;
  logic            r_vs_d;
  logic [CW-1:0]   r_tmo_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_req_ready, r_done, r_err, r_gen_reset_n, r_mode_valid;
  logic [1:0]      r_cur_mode;
  tmg_t            r_tmg;

  logic            w_accept, w_vs_rise, w_tmo, w_hold_done, w_enter_hold, w_enter_wait;
  logic [1:0]      w_load_mode;
  logic            w_done_nxt, w_err_nxt, w_grn_nxt, w_rdy_nxt, w_mv_nxt;

  assign w_accept     = req_valid & r_req_ready;
  assign w_vs_rise    = vs_in & ~r_vs_d;
  assign w_tmo        = (r_tmo_cnt >= CW'(TIMEOUT - 1));
  assign w_hold_done  = (r_hold_cnt == HW'(HOLD_CYCLES - 1));
  assign w_enter_hold = (w_next == S_HOLD) && (r_state != S_HOLD);
  assign w_enter_wait = ((w_next == S_DRAIN) || (w_next == S_START)) && (w_next != r_state);
  // From IDLE the accept and HOLD entry share an edge, so the table is indexed by the live request.
  assign w_load_mode  = (r_state == S_IDLE) ? req_mode : r_pend_mode;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; a VS edge in START wins over a simultaneous timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_HOLD;
      S_ACTIVE: if (w_accept) w_next = S_DRAIN;
      S_DRAIN:  if (w_vs_rise || w_tmo) w_next = S_HOLD;
      S_HOLD:   if (w_hold_done) w_next = S_START;
      S_START: begin
        if (w_vs_rise)  w_next = S_ACTIVE;
        else if (w_tmo) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    w_done_nxt = (r_state == S_START) && w_vs_rise;
    w_err_nxt  = (r_state == S_START) && !w_vs_rise && w_tmo;
    w_grn_nxt  = (w_next == S_ACTIVE) || (w_next == S_DRAIN) || (w_next == S_START);
    w_rdy_nxt  = (w_next == S_IDLE) || (w_next == S_ACTIVE);
    w_mv_nxt   = (w_next == S_ACTIVE);
  end

  // Output registers: glitch-free reset/handshake pins and timing set loaded only on HOLD entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_ready   <= 1'b1;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_gen_reset_n <= 1'b0;
      r_mode_valid  <= 1'b0;
      r_cur_mode    <= 2'd0;
      r_tmg         <= mode_tbl(2'd0);
    end else begin
      r_req_ready   <= w_rdy_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_gen_reset_n <= w_grn_nxt;
      r_mode_valid  <= w_mv_nxt;
      if (w_done_nxt)   r_cur_mode <= r_pend_mode;
      if (w_enter_hold) r_tmg      <= mode_tbl(w_load_mode);
    end
  end

  // Sequencing datapath: VS delay, pending mode, shared timeout counter and hold counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_d      <= 1'b0;
      r_pend_mode <= 2'd0;
      r_tmo_cnt   <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_vs_d <= vs_in;
      if (w_accept) r_pend_mode <= req_mode;
      if (w_enter_wait)
        r_tmo_cnt <= '0;
      else if (((r_state == S_DRAIN) || (r_state == S_START)) && (r_tmo_cnt != CW'(TIMEOUT)))
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_enter_hold)
        r_hold_cnt <= '0;
      else if ((r_state == S_HOLD) && !w_hold_done)
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign req_ready   = r_req_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign gen_reset_n = r_gen_reset_n;
  assign mode_valid  = r_mode_valid;
  assign cur_mode    = r_cur_mode;
  assign interlaced  = r_tmg.il;
  assign h_total     = r_tmg.h_total;
  assign h_fp        = r_tmg.h_fp;
  assign h_bp        = r_tmg.h_bp;
  assign h_sync      = r_tmg.h_sync;
  assign hv_offset_0 = r_tmg.hv0;
  assign hv_offset_1 = r_tmg.hv1;
  assign v_total_0   = r_tmg.vt0;
  assign v_fp_0      = r_tmg.vf0;
  assign v_bp_0      = r_tmg.vb0;
  assign v_sync_0    = r_tmg.vs0;
  assign v_total_1   = r_tmg.vt1;
  assign v_fp_1      = r_tmg.vf1;
  assign v_bp_1      = r_tmg.vb1;
  assign v_sync_1    = r_tmg.vs1;

endmodule

// File: tb/tb_vg_mode_ctrl.sv
// Bench for vg_mode_ctrl: random mode-change episodes with random VS timing, stuck-VS timeouts and a mid-HOLD async reset.
// Expected timelines come from episode arithmetic (drain length, hold length, start length) and a per-mode timing table.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_vg_mode_ctrl;

  localparam int XB   = 12;
  localparam int YB   = 12;
  localparam int HOLD = 16;
  localparam int TMO  = 100;

  typedef logic [191:0] cv_t;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, done, err, vs_in, gen_reset_n, mode_valid, interlaced;
  logic [1:0] req_mode, cur_mode;
  logic [YB-1:0] v_total_0, v_fp_0, v_bp_0, v_sync_0, v_total_1, v_fp_1, v_bp_1, v_sync_1;
  logic [XB-1:0] h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1;

  always #5 clk = ~clk;

  vg_mode_ctrl #(.X_BITS(XB), .Y_BITS(YB), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .done(done), .err(err), .vs_in(vs_in), .gen_reset_n(gen_reset_n), .mode_valid(mode_valid),
    .cur_mode(cur_mode), .interlaced(interlaced),
    .v_total_0(v_total_0), .v_fp_0(v_fp_0), .v_bp_0(v_bp_0), .v_sync_0(v_sync_0),
    .v_total_1(v_total_1), .v_fp_1(v_fp_1), .v_bp_1(v_bp_1), .v_sync_1(v_sync_1),
    .h_total(h_total), .h_fp(h_fp), .h_bp(h_bp), .h_sync(h_sync),
    .hv_offset_0(hv_offset_0), .hv_offset_1(hv_offset_1)
  );

  // Reference timing table: h_total,h_fp,h_bp,h_sync / v field 0 / v field 1 / hv_offset_1 / interlaced
  int tbl_h  [4][4] = '{'{1650,110,220,40}, '{2200,88,148,44}, '{2200,88,148,44}, '{858,16,60,62}};
  int tbl_v0 [4][4] = '{'{750,5,20,5},      '{1125,4,36,5},    '{562,2,15,5},     '{525,9,30,6}};
  int tbl_v1 [4][4] = '{'{750,5,20,5},      '{1125,4,36,5},    '{563,2,16,5},     '{525,9,30,6}};
  int tbl_hv1[4]    = '{0, 0, 1100, 0};
  int tbl_il [4]    = '{0, 0, 1, 0};

  int n_chk  = 0;
  int n_pass = 0;
  int m_cur;
  bit m_active;
  logic [168:0] prev_tv;

  task automatic chk(input string tag, input cv_t got, input cv_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [168:0] obs_tv();
    return {interlaced, h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1,
            v_total_0, v_fp_0, v_bp_0, v_sync_0, v_total_1, v_fp_1, v_bp_1, v_sync_1};
  endfunction

  function automatic logic [168:0] exp_tv(input int m);
    return {1'(tbl_il[m]),
            XB'(tbl_h[m][0]), XB'(tbl_h[m][1]), XB'(tbl_h[m][2]), XB'(tbl_h[m][3]),
            XB'(0), XB'(tbl_hv1[m]),
            YB'(tbl_v0[m][0]), YB'(tbl_v0[m][1]), YB'(tbl_v0[m][2]), YB'(tbl_v0[m][3]),
            YB'(tbl_v1[m][0]), YB'(tbl_v1[m][1]), YB'(tbl_v1[m][2]), YB'(tbl_v1[m][3])};
  endfunction

  // One clock; timing must never move while the generator is out of reset, done/err exclusive.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_reset_n === 1'b1) chk("tmg_stable", cv_t'(obs_tv()), cv_t'(prev_tv));
    chk("done_err_excl", cv_t'(done & err), cv_t'(0));
    prev_tv = obs_tv();
  endtask

  // One mode-change sequence: dl = edges in DRAIN, HOLD edges in reset, sl = edges in START.
  task automatic episode(input int idx);
    int m, dl, sl;
    bit dstuck, sstuck, from_act;
    m      = (idx == 0) ? 1 : (idx == 1) ? 2 : int'($urandom_range(0, 3));
    dstuck = (idx == 4) || ($urandom_range(0, 4) == 0);
    sstuck = (idx == 2) || ($urandom_range(0, 5) == 0);
    dl     = dstuck ? TMO : int'($urandom_range(1, 12));
    sl     = sstuck ? TMO : int'($urandom_range(1, 12));
    from_act = m_active;

    chk("rdy_before", cv_t'(req_ready), cv_t'(1));
    req_valid = 1'b1; req_mode = 2'(m); vs_in = 1'b0;
    tick();
    chk("rdy_drop", cv_t'(req_ready), cv_t'(0));
    chk("mv_drop", cv_t'(mode_valid), cv_t'(0));
    if (from_act) begin
      chk("drain_grn", cv_t'(gen_reset_n), cv_t'(1));
      for (int k = 1; k <= dl; k++) begin
        req_valid = 1'($urandom_range(0, 1)); req_mode = 2'($urandom_range(0, 3));
        vs_in = (!dstuck && k == dl);
        tick();
        if (k < dl) begin
          chk("drain_grn", cv_t'(gen_reset_n), cv_t'(1));
          chk("drain_rdy", cv_t'(req_ready), cv_t'(0));
        end
      end
    end
    chk("hold_grn", cv_t'(gen_reset_n), cv_t'(0));
    chk("hold_tmg", cv_t'(obs_tv()), cv_t'(exp_tv(m)));
    chk("drain_err", cv_t'(err), cv_t'(0));

    for (int k = 1; k <= HOLD; k++) begin
      req_valid = 1'($urandom_range(0, 1)); req_mode = 2'($urandom_range(0, 3));
      vs_in = (k < HOLD) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk("hold_rdy", cv_t'(req_ready), cv_t'(0));
      if (k < HOLD) chk("hold_grn", cv_t'(gen_reset_n), cv_t'(0));
      else          chk("release_grn", cv_t'(gen_reset_n), cv_t'(1));
    end

    for (int k = 1; k <= sl; k++) begin
      req_valid = 1'($urandom_range(0, 1)); req_mode = 2'($urandom_range(0, 3));
      vs_in = (!sstuck && k == sl);
      tick();
      if (k < sl) begin
        chk("start_done", cv_t'(done), cv_t'(0));
        chk("start_err", cv_t'(err), cv_t'(0));
        chk("start_grn", cv_t'(gen_reset_n), cv_t'(1));
      end
    end

    if (!sstuck) begin
      chk("done_pulse", cv_t'(done), cv_t'(1));
      chk("done_noerr", cv_t'(err), cv_t'(0));
      chk("done_mv", cv_t'(mode_valid), cv_t'(1));
      chk("done_cur", cv_t'(cur_mode), cv_t'(m));
      chk("done_grn", cv_t'(gen_reset_n), cv_t'(1));
      m_cur = m; m_active = 1'b1;
    end else begin
      chk("err_pulse", cv_t'(err), cv_t'(1));
      chk("err_nodone", cv_t'(done), cv_t'(0));
      chk("err_grn", cv_t'(gen_reset_n), cv_t'(0));
      chk("err_mv", cv_t'(mode_valid), cv_t'(0));
      chk("err_cur", cv_t'(cur_mode), cv_t'(m_cur));
      m_active = 1'b0;
    end
    chk("rdy_after", cv_t'(req_ready), cv_t'(1));
    req_valid = 1'b0; vs_in = 1'b0;
    tick();
    chk("pulse_end_done", cv_t'(done), cv_t'(0));
    chk("pulse_end_err", cv_t'(err), cv_t'(0));
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_mode = 2'd0; vs_in = 1'b0;
    #12;
    chk("rst_grn", cv_t'(gen_reset_n), cv_t'(0));
    chk("rst_mv", cv_t'(mode_valid), cv_t'(0));
    chk("rst_rdy", cv_t'(req_ready), cv_t'(1));
    chk("rst_done", cv_t'(done), cv_t'(0));
    chk("rst_err", cv_t'(err), cv_t'(0));
    chk("rst_cur", cv_t'(cur_mode), cv_t'(0));
    chk("rst_tmg", cv_t'(obs_tv()), cv_t'(exp_tv(0)));
    @(negedge clk);
    reset = 1'b1;
    prev_tv = obs_tv();
    m_cur = 0; m_active = 1'b0;
    tick();

    for (int i = 0; i < 30; i++) episode(i);

    // Async reset in the middle of HOLD with the request still asserted
    req_valid = 1'b1; req_mode = 2'd3; vs_in = 1'b0;
    tick();
    if (m_active) begin
      vs_in = 1'b1;
      tick();
      vs_in = 1'b0;
    end
    tick();
    tick();
    chk("midhold_rdy", cv_t'(req_ready), cv_t'(0));
    chk("midhold_grn", cv_t'(gen_reset_n), cv_t'(0));
    chk("midhold_tmg", cv_t'(obs_tv()), cv_t'(exp_tv(3)));
    #2 reset = 1'b0;
    #1;
    chk("arst_grn", cv_t'(gen_reset_n), cv_t'(0));
    chk("arst_mv", cv_t'(mode_valid), cv_t'(0));
    chk("arst_rdy", cv_t'(req_ready), cv_t'(1));
    chk("arst_done", cv_t'(done), cv_t'(0));
    chk("arst_err", cv_t'(err), cv_t'(0));
    chk("arst_cur", cv_t'(cur_mode), cv_t'(0));
    chk("arst_tmg", cv_t'(obs_tv()), cv_t'(exp_tv(0)));
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prev_tv = obs_tv();
    tick();
    chk("post_rst_grn", cv_t'(gen_reset_n), cv_t'(0));
    chk("post_rst_rdy", cv_t'(req_ready), cv_t'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
